// File: rtl/ms_timer_sched.sv
// rtl/ms_timer_sched.sv - multi-channel millisecond alarm scheduler with a shared round-robin comparator
module ms_timer_sched #(
    parameter int NUM_CH = 4,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ms_now,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] pending,
    output logic              irq
);

    localparam logic [1:0] REG_DEADLINE = 2'd0;
    localparam logic [1:0] REG_PERIOD   = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    logic [31:0]       deadline_q [NUM_CH];
    logic [31:0]       deadline_d [NUM_CH];
    logic [31:0]       period_q   [NUM_CH];
    logic [31:0]       period_d   [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [CW-1:0]     reg_ch;
    logic [1:0]        reg_sel;
    logic [31:0]       age;
    logic              expired;
    logic              collide;

    assign reg_ch  = CW'(addr >> 2);
    assign reg_sel = addr[1:0];

    // Wrap-safe: the deadline is in the past when it lies 0..2^31-1 ms behind ms_now.
    assign age     = ms_now - deadline_q[ptr_q];
    assign expired = (age < 32'h8000_0000);
    assign collide = we && (reg_ch == ptr_q);

    assign ptr_d = (ptr_q == CW'(NUM_CH - 1)) ? '0 : ptr_q + CW'(1);

    always_comb begin
        deadline_d = deadline_q;
        period_d   = period_q;
        en_d       = en_q;
        pend_d     = pend_q;

        // A software write to the visited channel suppresses the whole visit.
        if (!collide && en_q[ptr_q] && expired) begin
            pend_d[ptr_q] = 1'b1;
            if (period_q[ptr_q] != 32'd0) begin
                deadline_d[ptr_q] = deadline_q[ptr_q] + period_q[ptr_q];
            end else begin
                en_d[ptr_q] = 1'b0;
            end
        end

        if (we) begin
            case (reg_sel)
                REG_DEADLINE: deadline_d[reg_ch] = wdata;
                REG_PERIOD:   period_d[reg_ch]   = wdata;
                REG_CTRL:     en_d[reg_ch]       = wdata[0];
                REG_STATUS: begin
                    if (wdata[0]) begin
                        pend_d[reg_ch] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        case (reg_sel)
            REG_DEADLINE: rdata_d = deadline_q[reg_ch];
            REG_PERIOD:   rdata_d = period_q[reg_ch];
            REG_CTRL:     rdata_d = {31'd0, en_q[reg_ch]};
            REG_STATUS:   rdata_d = {31'd0, pend_q[reg_ch]};
            default:      rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                deadline_q[i] <= 32'd0;
                period_q[i]   <= 32'd0;
            end
            en_q    <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
            rdata_q <= 32'd0;
        end else begin
            deadline_q <= deadline_d;
            period_q   <= period_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign pending = pend_q;
    assign irq     = |pend_q;

endmodule

// File: tb/tb_ms_timer_sched.sv
// tb/tb_ms_timer_sched.sv - scoreboard bench for ms_timer_sched against a register-level reference model
module tb_ms_timer_sched;

    localparam int NUM_CH = 4;
    localparam int AW     = $clog2(NUM_CH) + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       ms_now = 32'd0;
    logic              we = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [31:0]       wdata = 32'd0;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pending;
    logic              irq;

    ms_timer_sched #(.NUM_CH(NUM_CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ms_now  (ms_now),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pending (pending),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       rd;
        logic [NUM_CH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the register file as software sees it, plus the visit slot.
    logic [31:0]       m_dl  [NUM_CH];
    logic [31:0]       m_per [NUM_CH];
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_pend;
    int                m_ptr;

    function automatic logic [31:0] m_reg(input int ch, input int r);
        case (r)
            0: return m_dl[ch];
            1: return m_per[ch];
            2: return {31'd0, m_en[ch]};
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    task automatic model_edge();
        exp_t        e;
        int          wc, wr, c;
        logic [31:0] behind;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_dl[i]  = 32'd0;
                m_per[i] = 32'd0;
            end
            m_en   = '0;
            m_pend = '0;
            m_ptr  = 0;
            e.rd   = 32'd0;
        end else begin
            wc   = int'(addr) / 4;
            wr   = int'(addr) % 4;
            e.rd = m_reg(wc, wr);
            c    = m_ptr;
            behind = ms_now - m_dl[c];
            if (!(we && wc == c) && m_en[c] && behind <= 32'h7FFF_FFFF) begin
                m_pend[c] = 1'b1;
                if (m_per[c] != 0) m_dl[c] = m_dl[c] + m_per[c];
                else               m_en[c] = 1'b0;
            end
            if (we) begin
                case (wr)
                    0: m_dl[wc]  = wdata;
                    1: m_per[wc] = wdata;
                    2: m_en[wc]  = wdata[0];
                    default: if (wdata[0]) m_pend[wc] = 1'b0;
                endcase
            end
            m_ptr = (m_ptr + 1) % NUM_CH;
        end
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp += 3;
            if (pending !== mon_e.pend) begin
                n_bad++;
                $display("FAIL mon_pending t=%0t: got %b expected %b", $time, pending, mon_e.pend);
            end
            if (irq !== (|mon_e.pend)) begin
                n_bad++;
                $display("FAIL mon_irq t=%0t: got %b expected %b", $time, irq, |mon_e.pend);
            end
            if (rdata !== mon_e.rd) begin
                n_bad++;
                $display("FAIL mon_rdata t=%0t: got %h expected %h", $time, rdata, mon_e.rd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        we    = 1'b1;
        addr  = AW'(ch * 4 + r);
        wdata = d;
        cyc();
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        we   = 1'b0;
        addr = AW'(ch * 4 + r);
        cyc();
        v = rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            we   = 1'b0;
            addr = AW'($urandom_range(0, 4 * NUM_CH - 1));
            cyc();
        end
    endtask

    task automatic wait_ptr(input int p);
        while (m_ptr != p) idle(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;

        do_reset();
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // One-shot on ch1
        ms_now = 32'd99;
        wr(1, 1, 32'd0); wr(1, 0, 32'd100); wr(1, 2, 32'd1);
        idle(8);
        chk("oneshot_early", 32'(pending[1]), 32'd0);
        ms_now = 32'd100;
        idle(4);
        chk("oneshot_fire", 32'(pending[1]), 32'd1);
        chk("oneshot_irq", 32'(irq), 32'd1);
        rd(1, 2, v);
        chk("oneshot_ctrl", v, 32'd0);
        wr(1, 3, 32'd1);
        chk("oneshot_clear", 32'(pending[1]), 32'd0);
        ms_now = 32'd101;
        idle(8);
        chk("oneshot_norefire", 32'(pending[1]), 32'd0);

        // Periodic on ch2
        ms_now = 32'd9;
        wr(2, 1, 32'd5); wr(2, 0, 32'd10); wr(2, 2, 32'd1);
        idle(8);
        chk("periodic_early", 32'(pending[2]), 32'd0);
        ms_now = 32'd10;
        idle(4);
        chk("periodic_fire1", 32'(pending[2]), 32'd1);
        rd(2, 0, v);
        chk("periodic_dl15", v, 32'd15);
        wr(2, 3, 32'd1);
        chk("periodic_clear", 32'(pending[2]), 32'd0);
        ms_now = 32'd15;
        idle(4);
        chk("periodic_fire2", 32'(pending[2]), 32'd1);
        rd(2, 0, v);
        chk("periodic_dl20", v, 32'd20);
        wr(2, 2, 32'd0);

        // Wrap-around on ch0
        ms_now = 32'hFFFF_FFFE;
        wr(0, 0, 32'd2); wr(0, 1, 32'd0); wr(0, 2, 32'd1);
        idle(8);
        chk("wrap_nofire", 32'(pending[0]), 32'd0);
        ms_now = 32'd2;
        idle(4);
        chk("wrap_fire", 32'(pending[0]), 32'd1);
        wr(0, 3, 32'd1);
        ms_now = 32'd5;
        wr(0, 0, 32'h8000_0005); wr(0, 2, 32'd1);
        idle(8);
        chk("wrap_future", 32'(pending[0]), 32'd0);
        wr(0, 2, 32'd0);

        // Collisions on ch3
        ms_now = 32'd2000;
        wr(3, 0, 32'd1000); wr(3, 1, 32'd0);
        wait_ptr(3);
        wr(3, 2, 32'd1);
        chk("coll_enable", 32'(pending[3]), 32'd0);
        wait_ptr(3);
        wr(3, 3, 32'd1);
        chk("coll_status", 32'(pending[3]), 32'd0);
        wait_ptr(3);
        wr(3, 0, 32'd1500);
        chk("coll_deadline", 32'(pending[3]), 32'd0);
        idle(4);
        chk("coll_later_fire", 32'(pending[3]), 32'd1);
        rd(3, 0, v);
        chk("coll_dl_kept", v, 32'd1500);
        rd(3, 2, v);
        chk("coll_autodisable", v, 32'd0);

        // Catch-up on ch1
        ms_now = 32'd3;
        wr(1, 3, 32'd1); wr(1, 1, 32'd1); wr(1, 0, 32'd0); wr(1, 2, 32'd1);
        idle(20);
        chk("catchup_pending", 32'(pending[1]), 32'd1);
        rd(1, 0, v);
        chk("catchup_dl", v, 32'd4);
        wr(1, 2, 32'd0);

        // All channels expiring together
        ms_now = 32'hFFFF_0000;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr(ch, 3, 32'd1); wr(ch, 1, 32'd0); wr(ch, 0, 32'hFFFF_0100); wr(ch, 2, 32'd1);
        end
        idle(8);
        chk("concur_none", 32'(pending), 32'd0);
        ms_now = 32'hFFFF_0100;
        idle(1);
        chk("concur_one", 32'($countones(pending)), 32'd1);
        idle(3);
        chk("concur_all", 32'(pending), 32'(4'hF));

        // Randomised traffic with occasional mid-run reset
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            case ($urandom_range(0, 49))
                0:          ms_now = $urandom();
                1,2,3,4,5,6,7,8,9,10,11,12: ms_now = ms_now + 32'd1;
                default:    ;
            endcase
            we   = ($urandom_range(0, 2) == 0);
            addr = AW'($urandom_range(0, 4 * NUM_CH - 1));
            case (addr[1:0])
                2'd0:    wdata = $urandom_range(0, 3) != 0 ? ms_now + 32'($urandom_range(0, 40)) - 32'd8
                                                           : $urandom();
                2'd1:    wdata = $urandom_range(0, 1) != 0 ? 32'd0 : 32'($urandom_range(1, 6));
                default: wdata = $urandom();
            endcase
            cyc();
        end
        rst_n = 1'b1;

        // Reset over whatever state the random run left
        idle(5);
        do_reset();
        chk("final_reset_pending", 32'(pending), 32'd0);
        chk("final_reset_irq", 32'(irq), 32'd0);
        for (int r = 0; r < 4; r++) begin
            rd(NUM_CH - 1, r, v);
            chk("final_reset_reg", v, 32'd0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ms_timer_sched.md
# ms_timer_sched

Multi-channel millisecond alarm scheduler layered on the free-running 32-bit millisecond count (16 MHz clock, 1 ms per increment). It holds NUM_CH independent one-shot or periodic alarms and shares one 32-bit wrap-safe comparator between them, visiting channels round-robin, one per clock. Expired alarms set per-channel pending bits and a combined interrupt. Software configures the block through a simple single-cycle register write/read port.

## Interface
- NUM_CH, 4: number of alarm channels; power of two, 1..16. AW = log2(NUM_CH)+2.
- clk  in  1  system clock, 16 MHz.
- rst_n  in  1  synchronous active-low reset.
- ms_now  in  32  current millisecond count from the ms counter.
- we  in  1  register write strobe, one cycle per write.
- addr  in  AW  register address: addr[AW-1:2] = channel c, addr[1:0] = register.
- wdata  in  32  write data.
- rdata  out  32  read data for the previous cycle's addr.
- pending  out  NUM_CH  per-channel expired flags.
- irq  out  1  OR of pending.

## Operation
- Per-channel registers, by addr[1:0]:
  - 0 DEADLINE[31:0]: ms value at which the alarm fires.
  - 1 PERIOD[31:0]: 0 = one-shot; otherwise the reload interval in ms.
  - 2 CTRL: bit0 = enable. Other bits read as 0.
  - 3 STATUS: read {31'b0, pending[c]}. Writing bit0 = 1 clears pending[c]. Writing bit0 = 0 has no effect.
- Scheduler pointer ptr: counts 0..NUM_CH-1 and wraps to 0, advancing every cycle while out of reset.
- Visit of channel c = ptr, when enable[c] = 1 and (ms_now - DEADLINE[c]) mod 2^32 has bit31 = 0 (expired):
  - pending[c] <= 1.
  - PERIOD != 0: DEADLINE[c] <= DEADLINE[c] + PERIOD[c] (mod 2^32); enable stays 1.
  - PERIOD == 0: enable[c] <= 0; DEADLINE unchanged.
- Expiry check is wrap-safe. A deadline counts as in the past if it is 0..2^31-1 ms behind ms_now.
- Pending is sticky. Multiple expiries before a clear collapse into one flag; there is no count.
- A periodic channel that falls behind advances by exactly one PERIOD per visit until it catches up.
- Disabling a channel (CTRL bit0 = 0) does not clear its pending bit.
- Writes to a channel that is not being visited take effect at the next edge with no interaction.

## Timing
- Reset (rst_n = 0 at a clk edge) zeroes all of the following: DEADLINE, PERIOD, enable, pending, ptr, rdata. irq = 0.
- Reset mid-operation discards all state, including alarms in progress.
- Writes are single-cycle: the register updates at the edge where we = 1.
- Read latency is 1 cycle: rdata at edge N+1 reflects addr at edge N, showing the register contents before any write at edge N.
- Fire latency: pending[c] rises at the end of the first visit of c at or after ms_now reaches DEADLINE[c]. This is at most NUM_CH cycles after the ms_now change.
- irq is combinational from pending, so it rises in the same cycle as pending.
- Collision rule: if we = 1 addresses channel c in the same cycle the scheduler visits c, the write takes priority and that visit's action is skipped entirely (no fire, no reload, no auto-disable). The channel is re-evaluated NUM_CH cycles later.
  - Consequence: a STATUS clear is never immediately undone by a fire in the same cycle.
  - Consequence: a new DEADLINE is never overwritten by a reload.
- Writes to other channels do not affect the visit.

## Test plan
- Reset: drive rst_n = 0 with random prior state -> all reads return 0; pending = 0; irq = 0; ptr restarts at 0 (channel 0 fires first for equal deadlines).
- One-shot: ch1 DEADLINE = 100, PERIOD = 0, enable = 1, ms_now steps 99 -> 100 -> pending[1] = 1 within 4 cycles of the step, irq = 1, CTRL reads 0. Write STATUS = 1 -> pending[1] = 0; no refire at ms_now = 101.
- Periodic: ch2 DEADLINE = 10, PERIOD = 5, ms_now = 10 -> pending[2] set, DEADLINE reads 15. Clear STATUS, ms_now = 15 -> fires again, DEADLINE = 20.
- Wrap-around: ch0 DEADLINE = 0x0000_0002, ms_now = 0xFFFF_FFFE -> no fire. ms_now = 0x0000_0002 -> fire. Also DEADLINE = 0x8000_0005 with ms_now = 5 -> no fire (treated as future).
- Collision: ch3 expired; write STATUS or DEADLINE of ch3 in exactly the cycle ptr = 3 -> write applied, no fire that cycle. Fire occurs on the visit 4 cycles later if still expired.
- Catch-up and concurrency: ch1 PERIOD = 1, DEADLINE = 0, ms_now = 3 -> DEADLINE advances 1, 2, 3, 4 on successive visits, pending stays 1. Meanwhile all 4 channels expire at the same ms_now -> each pending set in ptr order, one per cycle.
